// File: rtl/seven_sensor_pkg.sv
// Shared constants for the seven-sensor debounce block: channel count,
// parameter defaults and the width of the per-channel chatter counter.
package seven_sensor_pkg;

  localparam int NUM_SENSORS         = 7;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int FAULT_LIMIT_DEF     = 8;
  localparam int FAULT_CNT_W         = 4;

endpackage

// File: rtl/seven_sensor_debounce_channel.sv
// One sensor channel: synchronizer, debounce counter, stable level and update strobe.
// Chatter counting and the sticky fault flag are built only with SENSOR_FAULT_EN defined.
module debounce_channel
  import seven_sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int FAULT_LIMIT     = FAULT_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic upd,
  output logic fault
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CW-1:0]          cnt_r;
  logic [CW-1:0]          cnt_s;
  logic                   stable_r;
  logic                   upd_r;
  logic                   sync_s;
  logic                   hit_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Counter advances while the synchronized level disagrees; hitting the limit accepts it.
  always_comb begin
    hit_s = 1'b0;
    cnt_s = cnt_r;
    if (sync_s != stable_r) begin
      if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
        hit_s = 1'b1;
        cnt_s = '0;
      end else begin
        cnt_s = cnt_r + CW'(1);
      end
    end else begin
      cnt_s = '0;
    end
  end

  // Synchronizer shift, counter, stable level and the registered update strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r   <= '0;
      cnt_r    <= '0;
      stable_r <= 1'b0;
      upd_r    <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
      cnt_r  <= cnt_s;
      upd_r  <= hit_s;
      if (hit_s) begin
        stable_r <= sync_s;
      end else begin
        stable_r <= stable_r;
      end
    end
  end

  assign stable = stable_r;
  assign upd    = upd_r;

`ifdef SENSOR_FAULT_EN
  logic [FAULT_CNT_W-1:0] fcnt_r;
  logic [FAULT_CNT_W-1:0] fcnt_s;
  logic                   fault_r;
  logic                   abort_s;

  // A counter collapsing from a nonzero value without an update is an aborted transition.
  assign abort_s = (sync_s == stable_r) && (cnt_r != '0);

  // Saturating abort count; never wraps back below the limit.
  always_comb begin
    fcnt_s = fcnt_r;
    if (abort_s && (fcnt_r != {FAULT_CNT_W{1'b1}})) begin
      fcnt_s = fcnt_r + FAULT_CNT_W'(1);
    end else begin
      fcnt_s = fcnt_r;
    end
  end

  // Fault flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_r  <= '0;
      fault_r <= 1'b0;
    end else begin
      fcnt_r  <= fcnt_s;
      fault_r <= fault_r | (fcnt_s >= FAULT_CNT_W'(FAULT_LIMIT));
    end
  end

  assign fault = fault_r;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: rtl/seven_sensor_debounce.sv
// Seven independent debounced sensor channels with registered levels and change reporting.
// Optional chatter detection is enabled with macro SENSOR_FAULT_EN.
module seven_sensor_debounce
  import seven_sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int FAULT_LIMIT     = FAULT_LIMIT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SENSORS-1:0] raw,
  output logic                   X1,
  output logic                   X2,
  output logic                   X3,
  output logic                   X4,
  output logic                   X5,
  output logic                   X6,
  output logic                   X7,
  output logic                   changed,
  output logic [NUM_SENSORS-1:0] change_mask,
  output logic [NUM_SENSORS-1:0] fault
);

  logic [NUM_SENSORS-1:0] stable_s;
  logic [NUM_SENSORS-1:0] upd_s;
  logic [NUM_SENSORS-1:0] x_r;
  logic                   changed_r;
  logic [NUM_SENSORS-1:0] mask_r;

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .FAULT_LIMIT     (FAULT_LIMIT)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw[i]),
      .stable (stable_s[i]),
      .upd    (upd_s[i]),
      .fault  (fault[i])
    );
  end

  // Output stage: levels and change report are registered together so they align.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r       <= '0;
      changed_r <= 1'b0;
      mask_r    <= '0;
    end else begin
      x_r       <= stable_s;
      changed_r <= |upd_s;
      mask_r    <= upd_s;
    end
  end

  assign X1          = x_r[0];
  assign X2          = x_r[1];
  assign X3          = x_r[2];
  assign X4          = x_r[3];
  assign X5          = x_r[4];
  assign X6          = x_r[5];
  assign X7          = x_r[6];
  assign changed     = changed_r;
  assign change_mask = mask_r;

endmodule
